// File: rtl/rf_writeback_queue_pkg.sv
// Shared types for the register-file writeback queue.
package rf_writeback_queue_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    word_t    wdat;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_queue_if.sv
// Producer handshakes, register-file write port and forwarding lookup
// grouped into one bundle. slave = queue side, master = environment side.
interface rf_writeback_queue_if
  import rf_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             mem_valid;
  regbits_t         mem_wsel;
  word_t            mem_wdat;
  logic             mem_ready;
  logic             alu_valid;
  regbits_t         alu_wsel;
  word_t            alu_wdat;
  logic             alu_ready;
  logic             WEN;
  regbits_t         wsel;
  word_t            wdat;
  regbits_t         rsel1;
  regbits_t         rsel2;
  logic             fwd1_hit;
  word_t            fwd1_dat;
  logic             fwd2_hit;
  word_t            fwd2_dat;
  logic [PTR_W:0]   count;

  modport slave (
    input  mem_valid, mem_wsel, mem_wdat, alu_valid, alu_wsel, alu_wdat,
           rsel1, rsel2,
    output mem_ready, alu_ready, WEN, wsel, wdat,
           fwd1_hit, fwd1_dat, fwd2_hit, fwd2_dat, count
  );

  modport master (
    output mem_valid, mem_wsel, mem_wdat, alu_valid, alu_wsel, alu_wdat,
           rsel1, rsel2,
    input  mem_ready, alu_ready, WEN, wsel, wdat,
           fwd1_hit, fwd1_dat, fwd2_hit, fwd2_dat, count
  );
endinterface

// File: rtl/rf_writeback_queue_fwd_match.sv
// Youngest-match search over the pending queue entries for one read port.
module rf_wb_fwd_match
  import rf_writeback_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t        i_q [DEPTH],
  input  logic [PTR_W-1:0] i_rd_ptr,
  input  regbits_t         i_rsel,
  output logic             o_hit,
  output word_t            o_dat
);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match kept is the youngest one;
  // only occupied slots carry a set valid bit.
  always_comb begin
    o_hit = 1'b0;
    o_dat = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = i_rd_ptr + PTR_W'(k);
      if (i_q[w_idx].valid && (i_q[w_idx].wsel == i_rsel) && (i_rsel != '0)) begin
        o_hit = 1'b1;
        o_dat = i_q[w_idx].wdat;
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO feeding the register-file write port from the
// load-return and ALU producers, one commit per cycle.
// Build option: RF_WB_FORWARD_EN adds pending-write forwarding on rsel1/rsel2.
module rf_writeback_queue
  import rf_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                 CLK,
  input logic                 RST,
  rf_writeback_queue_if.slave bus
);

  localparam int unsigned     PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);

  wb_entry_t        r_q [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic [PTR_W:0]   w_free;
  logic             w_mem_ready;
  logic             w_alu_ready;
  logic             w_mem_push;
  logic             w_alu_push;
  logic             w_pop;
  logic [1:0]       w_npush;
  logic [PTR_W-1:0] w_alu_slot;
  logic [PTR_W:0]   w_count_next;

  // Readiness ignores the same-cycle pop; mem has priority for the last slot.
  always_comb begin
    w_free       = DEPTH_C - r_count;
    w_mem_ready  = (w_free != '0);
    w_alu_ready  = (w_free >= (PTR_W + 1)'(2)) || ((w_free != '0) && !bus.mem_valid);
    // Writes to register zero are accepted but never stored.
    w_mem_push   = bus.mem_valid && w_mem_ready && (bus.mem_wsel != '0);
    w_alu_push   = bus.alu_valid && w_alu_ready && (bus.alu_wsel != '0);
    w_pop        = r_q[r_rd_ptr].valid;
    w_npush      = {1'b0, w_mem_push} + {1'b0, w_alu_push};
    w_alu_slot   = r_wr_ptr + PTR_W'(w_mem_push);
    w_count_next = r_count + (PTR_W + 1)'(w_npush) - (PTR_W + 1)'(w_pop);
  end

  // Queue state: pop the head every non-empty cycle, append accepted writes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q[i].valid <= 1'b0;
      end
    end else begin
      if (w_pop) begin
        r_q[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr            <= r_rd_ptr + PTR_W'(1);
      end
      if (w_mem_push) begin
        r_q[r_wr_ptr] <= {1'b1, bus.mem_wsel, bus.mem_wdat};
      end
      if (w_alu_push) begin
        r_q[w_alu_slot] <= {1'b1, bus.alu_wsel, bus.alu_wdat};
      end
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
      r_count  <= w_count_next;
    end
  end

  // Drain port driven straight from the head entry.
  always_comb begin
    bus.WEN       = w_pop;
    bus.wsel      = w_pop ? r_q[r_rd_ptr].wsel : '0;
    bus.wdat      = w_pop ? r_q[r_rd_ptr].wdat : '0;
    bus.mem_ready = w_mem_ready;
    bus.alu_ready = w_alu_ready;
    bus.count     = r_count;
  end

`ifdef RF_WB_FORWARD_EN
  rf_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .i_q      (r_q),
    .i_rd_ptr (r_rd_ptr),
    .i_rsel   (bus.rsel1),
    .o_hit    (bus.fwd1_hit),
    .o_dat    (bus.fwd1_dat)
  );

  rf_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .i_q      (r_q),
    .i_rd_ptr (r_rd_ptr),
    .i_rsel   (bus.rsel2),
    .o_hit    (bus.fwd2_hit),
    .o_dat    (bus.fwd2_dat)
  );
`else
  logic w_unused_rsel;

  // Lookup selects are kept on the interface but not used in this build.
  always_comb begin
    w_unused_rsel = ^{bus.rsel1, bus.rsel2};
    bus.fwd1_hit  = 1'b0;
    bus.fwd1_dat  = '0;
    bus.fwd2_hit  = 1'b0;
    bus.fwd2_dat  = '0;
  end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_rf_writeback_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] dat;
  } ent_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  rf_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int   n_total = 0;
  int   n_pass  = 0;
  bit   live    = 1'b0;
  ent_t mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void model_fwd(input logic [4:0] r, output logic hit, output logic [31:0] dat);
    hit = 1'b0;
    dat = '0;
`ifdef RF_WB_FORWARD_EN
    if (r != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].sel == r) begin
          hit = 1'b1;
          dat = mq[i].dat;
          break;
        end
      end
    end
`endif
  endfunction

  // Reference model: compare every cycle at the falling edge, then advance.
  always @(negedge CLK) begin
    int          sz;
    int          free;
    logic        e_mr, e_ar, h1, h2;
    logic [31:0] d1, d2;
    ent_t        e;
    sz   = mq.size();
    free = DEPTH - sz;
    e_mr = (free >= 1);
    e_ar = (free >= 2) || (free >= 1 && !bus.mem_valid);
    if (live) begin
      model_fwd(bus.rsel1, h1, d1);
      model_fwd(bus.rsel2, h2, d2);
      chk("m_WEN", 32'(bus.WEN), 32'(sz != 0));
      chk("m_wsel", 32'(bus.wsel), (sz != 0) ? 32'(mq[0].sel) : 32'd0);
      chk("m_wdat", bus.wdat, (sz != 0) ? mq[0].dat : 32'd0);
      chk("m_count", 32'(bus.count), 32'(sz));
      chk("m_mem_ready", 32'(bus.mem_ready), 32'(e_mr));
      chk("m_alu_ready", 32'(bus.alu_ready), 32'(e_ar));
      chk("m_fwd1_hit", 32'(bus.fwd1_hit), 32'(h1));
      chk("m_fwd1_dat", bus.fwd1_dat, d1);
      chk("m_fwd2_hit", 32'(bus.fwd2_hit), 32'(h2));
      chk("m_fwd2_dat", bus.fwd2_dat, d2);
    end
    if (RST) begin
      mq.delete();
      live = 1'b1;
    end else if (live) begin
      if (sz != 0) void'(mq.pop_front());
      if (bus.mem_valid && e_mr && bus.mem_wsel != 5'd0) begin
        e.sel = bus.mem_wsel; e.dat = bus.mem_wdat; mq.push_back(e);
      end
      if (bus.alu_valid && e_ar && bus.alu_wsel != 5'd0) begin
        e.sel = bus.alu_wsel; e.dat = bus.alu_wdat; mq.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.mem_valid = 1'b0; bus.mem_wsel = '0; bus.mem_wdat = '0;
    bus.alu_valid = 1'b0; bus.alu_wsel = '0; bus.alu_wdat = '0;
  endtask

  task automatic set_mem(input logic [4:0] s, input logic [31:0] d);
    bus.mem_valid = 1'b1; bus.mem_wsel = s; bus.mem_wdat = d;
  endtask

  task automatic set_alu(input logic [4:0] s, input logic [31:0] d);
    bus.alu_valid = 1'b1; bus.alu_wsel = s; bus.alu_wdat = d;
  endtask

  initial begin
    logic fwd_on;
`ifdef RF_WB_FORWARD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    idle();
    bus.rsel1 = '0;
    bus.rsel2 = '0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;

    // Reset state
    chk("rst_WEN", 32'(bus.WEN), 32'd0);
    chk("rst_wsel", 32'(bus.wsel), 32'd0);
    chk("rst_wdat", bus.wdat, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_fwd1_hit", 32'(bus.fwd1_hit), 32'd0);
    chk("rst_fwd1_dat", bus.fwd1_dat, 32'd0);

    // Single ALU write
    set_alu(5'd5, 32'hDEADBEEF);
    step();
    idle();
    chk("alu1_WEN", 32'(bus.WEN), 32'd1);
    chk("alu1_wsel", 32'(bus.wsel), 32'd5);
    chk("alu1_wdat", bus.wdat, 32'hDEADBEEF);
    step();
    chk("alu1_WEN_after", 32'(bus.WEN), 32'd0);
    chk("alu1_count_after", 32'(bus.count), 32'd0);

    // Simultaneous mem + ALU: mem commits first
    set_mem(5'd3, 32'h11);
    set_alu(5'd4, 32'h22);
    step();
    idle();
    chk("pair_count", 32'(bus.count), 32'd2);
    chk("pair_first_wsel", 32'(bus.wsel), 32'd3);
    chk("pair_first_wdat", bus.wdat, 32'h11);
    step();
    chk("pair_second_WEN", 32'(bus.WEN), 32'd1);
    chk("pair_second_wsel", 32'(bus.wsel), 32'd4);
    chk("pair_second_wdat", bus.wdat, 32'h22);
    step();
    chk("pair_empty_WEN", 32'(bus.WEN), 32'd0);

    // Forwarding: 7/0xA then 7/0xB pending, youngest wins
    set_mem(5'd7, 32'hA);
    set_alu(5'd7, 32'hB);
    bus.rsel1 = 5'd7;
    bus.rsel2 = 5'd0;
    step();
    idle();
    chk("fwd_count", 32'(bus.count), 32'd2);
    chk("fwd1_hit", 32'(bus.fwd1_hit), 32'(fwd_on));
    chk("fwd1_dat", bus.fwd1_dat, fwd_on ? 32'hB : 32'd0);
    chk("fwd2_hit", 32'(bus.fwd2_hit), 32'd0);
    step();
    chk("fwd1_dat_head", bus.fwd1_dat, fwd_on ? 32'hB : 32'd0);
    step();
    chk("fwd1_hit_empty", 32'(bus.fwd1_hit), 32'd0);
    bus.rsel1 = '0;

    // Register zero: accepted, never stored
    set_alu(5'd0, 32'hFFFFFFFF);
    #1;
    chk("r0_alu_ready", 32'(bus.alu_ready), 32'd1);
    step();
    idle();
    chk("r0_count", 32'(bus.count), 32'd0);
    chk("r0_WEN", 32'(bus.WEN), 32'd0);
    step();
    chk("r0_WEN_later", 32'(bus.WEN), 32'd0);

    // Fill while draining: steady state at count=3 refuses the ALU
    for (int i = 0; i < 6; i++) begin
      set_mem(5'(8 + 2 * i), 32'h100 + 32'(i));
      set_alu(5'(9 + 2 * i), 32'h200 + 32'(i));
      step();
      if (i >= 1) begin
        chk("fill_count", 32'(bus.count), 32'd3);
        chk("fill_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("fill_alu_ready", 32'(bus.alu_ready), 32'd0);
      end
    end

    // Reset with count=3 and requests still presented
    RST = 1'b1;
    step();
    RST = 1'b0;
    idle();
    chk("midrst_WEN", 32'(bus.WEN), 32'd0);
    chk("midrst_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_stale", 32'(bus.WEN), 32'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      RST           = ($urandom_range(0, 99) == 0);
      bus.mem_valid = ($urandom_range(0, 3) != 0);
      bus.mem_wsel  = 5'($urandom_range(0, 7));
      bus.mem_wdat  = $urandom;
      bus.alu_valid = ($urandom_range(0, 3) != 0);
      bus.alu_wsel  = 5'($urandom_range(0, 7));
      bus.alu_wdat  = $urandom;
      bus.rsel1     = 5'($urandom_range(0, 7));
      bus.rsel2     = 5'($urandom_range(0, 7));
      step();
    end
    RST = 1'b0;
    idle();
    repeat (DEPTH + 2) step();
    chk("drain_count", 32'(bus.count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
